lc4_regfile_ss: RTL and testbench

Two-wide register file for the superscalar LC4 datapath, parametrised in word width and register count. It has four read ports (rs/rt for pipes A and B) and two write ports (A older, B younger). Same-cycle write-to-read bypass makes a value written in cycle t visible on reads in cycle t. A per-register busy scoreboard lets decode stall on in-flight producers.

---
 rtl/lc4_regfile_pkg.sv | 21 ++
 rtl/lc4_regfile_ss_if.sv | 36 +++
 rtl/lc4_regfile_rdport.sv | 37 +++
 rtl/lc4_regfile_ss.sv | 90 +++++++++
 tb/tb_lc4_regfile_ss.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/lc4_regfile_pkg.sv
// Shared constants and bypass-priority helper for the superscalar LC4 register file.
// The same priority function drives read bypass, register write-merge and busy clears.
package lc4_regfile_pkg;

  localparam int LC4_WORD  = 16;
  localparam int LC4_NREGS = 8;

  typedef enum logic [1:0] {
    SRC_REG = 2'd0,
    SRC_A   = 2'd1,
    SRC_B   = 2'd2
  } byp_src_e;

  // Pipe B is younger, so its write wins over pipe A on a shared target.
  function automatic byp_src_e byp_src(input logic hit_a, input logic hit_b);
    if (hit_b) return SRC_B;
    if (hit_a) return SRC_A;
    return SRC_REG;
  endfunction

endpackage

// File: rtl/lc4_regfile_ss_if.sv
// Read/write/allocate bus of the two-wide LC4 register file.
interface lc4_regfile_ss_if
  import lc4_regfile_pkg::*;
#(
  parameter int n     = LC4_WORD,
  parameter int nregs = LC4_NREGS
);
  localparam int r = $clog2(nregs);

  logic         gwe;
  logic [r-1:0] i_rs_A, i_rt_A, i_rs_B, i_rt_B;
  logic [n-1:0] o_rs_A_data, o_rt_A_data, o_rs_B_data, o_rt_B_data;
  logic         o_rs_A_busy, o_rt_A_busy, o_rs_B_busy, o_rt_B_busy;
  logic [r-1:0] i_rd_A, i_rd_B;
  logic [n-1:0] i_wdata_A, i_wdata_B;
  logic         i_rd_we_A, i_rd_we_B;
  logic         i_alloc_we;
  logic [r-1:0] i_alloc_rd;

  modport master (
    output gwe, i_rs_A, i_rt_A, i_rs_B, i_rt_B,
    output i_rd_A, i_rd_B, i_wdata_A, i_wdata_B, i_rd_we_A, i_rd_we_B,
    output i_alloc_we, i_alloc_rd,
    input  o_rs_A_data, o_rt_A_data, o_rs_B_data, o_rt_B_data,
    input  o_rs_A_busy, o_rt_A_busy, o_rs_B_busy, o_rt_B_busy
  );

  modport slave (
    input  gwe, i_rs_A, i_rt_A, i_rs_B, i_rt_B,
    input  i_rd_A, i_rd_B, i_wdata_A, i_wdata_B, i_rd_we_A, i_rd_we_B,
    input  i_alloc_we, i_alloc_rd,
    output o_rs_A_data, o_rt_A_data, o_rs_B_data, o_rt_B_data,
    output o_rs_A_busy, o_rt_A_busy, o_rs_B_busy, o_rt_B_busy
  );

endinterface

// File: rtl/lc4_regfile_rdport.sv
// One read port: register mux with same-cycle write bypass and scoreboard lookup.
module lc4_regfile_rdport
  import lc4_regfile_pkg::*;
#(
  parameter  int n     = LC4_WORD,
  parameter  int nregs = LC4_NREGS,
  localparam int r     = $clog2(nregs)
) (
  input  logic [r-1:0]     i_sel,
  input  logic [n-1:0]     i_regs [nregs],
  input  logic [nregs-1:0] i_busy,
  input  logic             i_we_a,
  input  logic [r-1:0]     i_rd_a,
  input  logic [n-1:0]     i_wdata_a,
  input  logic             i_we_b,
  input  logic [r-1:0]     i_rd_b,
  input  logic [n-1:0]     i_wdata_b,
  output logic [n-1:0]     o_data,
  output logic             o_busy
);

  byp_src_e src;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    src    = byp_src(i_we_a && (i_rd_a == i_sel), i_we_b && (i_rd_b == i_sel));
    o_data = i_regs[i_sel];
    case (src)
      SRC_B:   o_data = i_wdata_b;
      SRC_A:   o_data = i_wdata_a;
      default: o_data = i_regs[i_sel];
    endcase
    // A producer writing back this cycle retires the busy bit early.
    o_busy = i_busy[i_sel] && (src == SRC_REG);
  end

endmodule

// File: rtl/lc4_regfile_ss.sv
// Two-wide LC4 register file: storage, write merge and busy scoreboard; four bypassed read ports.
module lc4_regfile_ss
  import lc4_regfile_pkg::*;
#(
  parameter int n     = LC4_WORD,
  parameter int nregs = LC4_NREGS
) (
  input logic             clk,
  input logic             rst,
  lc4_regfile_ss_if.slave bus
);

  localparam int r = $clog2(nregs);

  logic [n-1:0]     regs_q [nregs];
  logic [n-1:0]     regs_d [nregs];
  logic [nregs-1:0] busy_q, busy_d;

  logic we_a, we_b, alloc;
  assign we_a  = bus.i_rd_we_A  & bus.gwe;
  assign we_b  = bus.i_rd_we_B  & bus.gwe;
  assign alloc = bus.i_alloc_we & bus.gwe;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int k = 0; k < nregs; k++) begin
      case (byp_src(we_a && (bus.i_rd_A == r'(k)), we_b && (bus.i_rd_B == r'(k))))
        SRC_B: begin
          regs_d[k] = bus.i_wdata_B;
          busy_d[k] = 1'b0;
        end
        SRC_A: begin
          regs_d[k] = bus.i_wdata_A;
          busy_d[k] = 1'b0;
        end
        default: ;
      endcase
      // A newly issued producer supersedes the one writing back now.
      if (alloc && (bus.i_alloc_rd == r'(k))) busy_d[k] = 1'b1;
    end
  end

  // NOTE: the array is a handful of flops, not a RAM, so every entry is cleared by reset.
  // NOTE: state is updated only with non-blocking assignments to avoid ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  logic [r-1:0] rd_sel  [4];
  logic [n-1:0] rd_data [4];
  logic         rd_busy [4];

  assign rd_sel[0] = bus.i_rs_A;
  assign rd_sel[1] = bus.i_rt_A;
  assign rd_sel[2] = bus.i_rs_B;
  assign rd_sel[3] = bus.i_rt_B;

  for (genvar p = 0; p < 4; p++) begin : g_rdport
    lc4_regfile_rdport #(.n(n), .nregs(nregs)) u_rdport (
      .i_sel     (rd_sel[p]),
      .i_regs    (regs_q),
      .i_busy    (busy_q),
      .i_we_a    (we_a),
      .i_rd_a    (bus.i_rd_A),
      .i_wdata_a (bus.i_wdata_A),
      .i_we_b    (we_b),
      .i_rd_b    (bus.i_rd_B),
      .i_wdata_b (bus.i_wdata_B),
      .o_data    (rd_data[p]),
      .o_busy    (rd_busy[p])
    );
  end

  assign bus.o_rs_A_data = rd_data[0];
  assign bus.o_rt_A_data = rd_data[1];
  assign bus.o_rs_B_data = rd_data[2];
  assign bus.o_rt_B_data = rd_data[3];
  assign bus.o_rs_A_busy = rd_busy[0];
  assign bus.o_rt_A_busy = rd_busy[1];
  assign bus.o_rs_B_busy = rd_busy[2];
  assign bus.o_rt_B_busy = rd_busy[3];

endmodule

// File: tb/tb_lc4_regfile_ss.sv
// Directed bench for lc4_regfile_ss: default 16x8 instance plus a 32x16 instance.
module tb_lc4_regfile_ss;

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  lc4_regfile_ss_if #(.n(16), .nregs(8))  a_if ();
  lc4_regfile_ss_if #(.n(32), .nregs(16)) b_if ();

  lc4_regfile_ss #(.n(16), .nregs(8))  u_dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  lc4_regfile_ss #(.n(32), .nregs(16)) u_dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic quiet_a();
    a_if.gwe        = 1'b1;
    a_if.i_rd_we_A  = 1'b0;
    a_if.i_rd_we_B  = 1'b0;
    a_if.i_alloc_we = 1'b0;
    a_if.i_rd_A     = '0;
    a_if.i_rd_B     = '0;
    a_if.i_wdata_A  = '0;
    a_if.i_wdata_B  = '0;
    a_if.i_alloc_rd = '0;
  endtask

  task automatic quiet_b();
    b_if.gwe        = 1'b1;
    b_if.i_rd_we_A  = 1'b0;
    b_if.i_rd_we_B  = 1'b0;
    b_if.i_alloc_we = 1'b0;
    b_if.i_rd_A     = '0;
    b_if.i_rd_B     = '0;
    b_if.i_wdata_A  = '0;
    b_if.i_wdata_B  = '0;
    b_if.i_alloc_rd = '0;
  endtask

  task automatic sel_a(input logic [2:0] rs_a, rt_a, rs_b, rt_b);
    a_if.i_rs_A = rs_a;
    a_if.i_rt_A = rt_a;
    a_if.i_rs_B = rs_b;
    a_if.i_rt_B = rt_b;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  initial begin
    rst = 1'b1;
    quiet_a();
    quiet_b();
    sel_a(3'd0, 3'd0, 3'd0, 3'd0);
    b_if.i_rs_A = '0; b_if.i_rt_A = '0; b_if.i_rs_B = '0; b_if.i_rt_B = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fill every register with FFFF; r1 is also allocated while being written.
    for (int k = 0; k < 4; k++) begin
      a_if.i_rd_we_A = 1'b1; a_if.i_rd_A = 3'(2 * k);     a_if.i_wdata_A = 16'hFFFF;
      a_if.i_rd_we_B = 1'b1; a_if.i_rd_B = 3'(2 * k + 1); a_if.i_wdata_B = 16'hFFFF;
      a_if.i_alloc_we = (k == 0);
      a_if.i_alloc_rd = 3'd1;
      @(negedge clk);
    end
    quiet_a();
    sel_a(3'd0, 3'd1, 3'd6, 3'd7);
    #1;
    check("prefill_rs_A", 32'(a_if.o_rs_A_data), 32'h0000FFFF);
    check("prefill_rt_B", 32'(a_if.o_rt_B_data), 32'h0000FFFF);
    check("alloc_beats_clear_busy", 32'(a_if.o_rt_A_busy), 32'd1);

    // Asynchronous reset between edges.
    #1 rst = 1'b1;
    #1;
    check("rst_rs_A", 32'(a_if.o_rs_A_data), 32'h0);
    check("rst_rt_A", 32'(a_if.o_rt_A_data), 32'h0);
    check("rst_rs_B", 32'(a_if.o_rs_B_data), 32'h0);
    check("rst_rt_B", 32'(a_if.o_rt_B_data), 32'h0);
    check("rst_busy", 32'({a_if.o_rs_A_busy, a_if.o_rt_A_busy, a_if.o_rs_B_busy, a_if.o_rt_B_busy}), 32'h0);
    a_if.i_rd_we_A = 1'b1; a_if.i_rd_A = 3'd4; a_if.i_wdata_A = 16'h1111;
    sel_a(3'd4, 3'd1, 3'd6, 3'd7);
    #1;
    check("rst_bypass", 32'(a_if.o_rs_A_data), 32'h00001111);
    @(negedge clk);
    rst = 1'b0;
    quiet_a();
    #1;
    check("rst_write_discarded", 32'(a_if.o_rs_A_data), 32'h0);

    // Write-then-read with bypass.
    a_if.i_rd_we_A = 1'b1; a_if.i_rd_A = 3'd3; a_if.i_wdata_A = 16'h1234;
    sel_a(3'd3, 3'd0, 3'd0, 3'd3);
    #1;
    check("wr_bypass_rs_A", 32'(a_if.o_rs_A_data), 32'h00001234);
    check("wr_bypass_rt_B", 32'(a_if.o_rt_B_data), 32'h00001234);
    @(negedge clk);
    quiet_a();
    #1;
    check("wr_stored_rs_A", 32'(a_if.o_rs_A_data), 32'h00001234);
    check("wr_stored_rt_B", 32'(a_if.o_rt_B_data), 32'h00001234);

    // Both write ports target r5: pipe B wins.
    @(negedge clk);
    a_if.i_rd_we_A = 1'b1; a_if.i_rd_A = 3'd5; a_if.i_wdata_A = 16'hAAAA;
    a_if.i_rd_we_B = 1'b1; a_if.i_rd_B = 3'd5; a_if.i_wdata_B = 16'h5555;
    sel_a(3'd5, 3'd5, 3'd3, 3'd0);
    #1;
    check("conflict_bypass", 32'(a_if.o_rs_A_data), 32'h00005555);
    check("other_reg_intact", 32'(a_if.o_rs_B_data), 32'h00001234);
    @(negedge clk);
    quiet_a();
    #1;
    check("conflict_stored", 32'(a_if.o_rt_A_data), 32'h00005555);

    // Scoreboard on r2 read through rs_B.
    @(negedge clk);
    sel_a(3'd0, 3'd0, 3'd2, 3'd0);
    a_if.i_alloc_we = 1'b1; a_if.i_alloc_rd = 3'd2;
    #1;
    check("alloc_not_same_cycle", 32'(a_if.o_rs_B_busy), 32'd0);
    @(negedge clk);
    quiet_a();
    #1;
    check("alloc_next_cycle", 32'(a_if.o_rs_B_busy), 32'd1);
    @(negedge clk);
    a_if.i_rd_we_B = 1'b1; a_if.i_rd_B = 3'd2; a_if.i_wdata_B = 16'h0042;
    #1;
    check("clear_bypass_busy", 32'(a_if.o_rs_B_busy), 32'd0);
    check("clear_bypass_data", 32'(a_if.o_rs_B_data), 32'h00000042);
    @(negedge clk);
    quiet_a();
    #1;
    check("clear_stays", 32'(a_if.o_rs_B_busy), 32'd0);
    @(negedge clk);
    a_if.i_alloc_we = 1'b1; a_if.i_alloc_rd = 3'd2;
    a_if.i_rd_we_A  = 1'b1; a_if.i_rd_A = 3'd2; a_if.i_wdata_A = 16'h0077;
    #1;
    check("alloc_and_clear_now", 32'(a_if.o_rs_B_busy), 32'd0);
    @(negedge clk);
    quiet_a();
    #1;
    check("alloc_beats_clear", 32'(a_if.o_rs_B_busy), 32'd1);
    check("alloc_and_write_data", 32'(a_if.o_rs_B_data), 32'h00000077);

    // gwe low freezes everything.
    @(negedge clk);
    sel_a(3'd7, 3'd0, 3'd0, 3'd0);
    a_if.gwe = 1'b0;
    a_if.i_rd_we_A  = 1'b1; a_if.i_rd_A = 3'd7; a_if.i_wdata_A = 16'hBEEF;
    a_if.i_alloc_we = 1'b1; a_if.i_alloc_rd = 3'd7;
    #1;
    check("gwe_no_bypass", 32'(a_if.o_rs_A_data), 32'h0);
    @(negedge clk);
    quiet_a();
    #1;
    check("gwe_no_write", 32'(a_if.o_rs_A_data), 32'h0);
    check("gwe_no_alloc", 32'(a_if.o_rs_A_busy), 32'd0);

    // Wide instance: 32-bit words, 16 registers.
    b_if.i_rd_we_A = 1'b1; b_if.i_rd_A = 4'd15; b_if.i_wdata_A = 32'hDEADBEEF;
    b_if.i_rd_we_B = 1'b1; b_if.i_rd_B = 4'd0;  b_if.i_wdata_B = 32'hDEADBEEF;
    b_if.i_rs_A = 4'd15; b_if.i_rt_A = 4'd0; b_if.i_rs_B = 4'd15; b_if.i_rt_B = 4'd0;
    #1;
    check("wide_bypass_rs_A", b_if.o_rs_A_data, 32'hDEADBEEF);
    check("wide_bypass_rt_A", b_if.o_rt_A_data, 32'hDEADBEEF);
    check("wide_bypass_rs_B", b_if.o_rs_B_data, 32'hDEADBEEF);
    check("wide_bypass_rt_B", b_if.o_rt_B_data, 32'hDEADBEEF);
    @(negedge clk);
    quiet_b();
    #1;
    check("wide_stored_rs_A", b_if.o_rs_A_data, 32'hDEADBEEF);
    check("wide_stored_rt_B", b_if.o_rt_B_data, 32'hDEADBEEF);
    @(negedge clk);
    b_if.i_rd_we_A = 1'b1; b_if.i_rd_A = 4'd15; b_if.i_wdata_A = 32'h12345678;
    @(negedge clk);
    quiet_b();
    b_if.i_rs_B = 4'd7;
    #1;
    check("wide_r15_rewrite", b_if.o_rs_A_data, 32'h12345678);
    check("wide_r0_intact", b_if.o_rt_A_data, 32'hDEADBEEF);
    check("wide_r7_zero", b_if.o_rs_B_data, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
